// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI command sequencer.
//  seq_state_t  : top-level frame FSM states
//  xfer_state_t : byte handshake FSM states
//  cmd_byte()   : selects one of the six command frame bytes by index
package sd_spi_pkg;

  typedef enum logic [3:0] {
    SeqIdle,
    SeqConf,
    SeqSel,
    SeqCmd,
    SeqPoll,
    SeqResp,
    SeqTail,
    SeqDesel,
    SeqDone
  } seq_state_t;

  typedef enum logic [1:0] {
    XferIdle,
    XferIssue,
    XferWaitHi,
    XferWaitLo
  } xfer_state_t;

  localparam logic [7:0]  FILL_BYTE  = 8'hFF;
  localparam logic [1:0]  CMD_START  = 2'b01;
  localparam int unsigned CMD_BYTES  = 6;
  localparam int unsigned RESP_MAX_C = 4;

  // Byte 0 carries start/transmission bits, bytes 1-4 the argument MSB first,
  // byte 5 the CRC7 with the mandatory end bit.
  function automatic logic [7:0] cmd_byte(input logic [2:0]  idx,
                                          input logic [5:0]  cmd_idx,
                                          input logic [31:0] arg,
                                          input logic [6:0]  crc);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {CMD_START, cmd_idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      3'd5:    b = {crc, 1'b1};
      default: b = FILL_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Link between the command sequencer and the byte-level SPI master.
//  spi_data_in  : byte to transmit, or divider value during a conf pulse
//  spi_w_data   : 1-cycle transmit strobe
//  spi_w_conf   : 1-cycle divider load strobe
//  spi_ss_in    : chip select, 0 = card selected
//  spi_busy     : master busy with a byte
//  spi_data_out : received byte, valid once busy has fallen
// modport master = sequencer side, modport slave = SPI master side.
interface sd_cmd_sequencer_if;
  logic [7:0] spi_data_in;
  logic       spi_w_data;
  logic       spi_w_conf;
  logic       spi_ss_in;
  logic       spi_busy;
  logic [7:0] spi_data_out;

  modport master (
    output spi_data_in,
    output spi_w_data,
    output spi_w_conf,
    output spi_ss_in,
    input  spi_busy,
    input  spi_data_out
  );

  modport slave (
    input  spi_data_in,
    input  spi_w_data,
    input  spi_w_conf,
    input  spi_ss_in,
    output spi_busy,
    output spi_data_out
  );
endinterface

// File: rtl/spi_byte_xfer.sv
// One-byte handshake with the SPI master.
//  clk, rst        : clock, asynchronous active-low reset
//  go, tx          : request to send tx (accepted only when idle)
//  rx, byte_done   : received byte and 1-cycle completion pulse (rx valid with it)
//  tx_byte         : byte held on the master's data input for the transfer
//  w_data          : transmit strobe to the master
//  busy, data_out  : master status and received byte
module spi_byte_xfer
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       byte_done,
  output logic [7:0] tx_byte,
  output logic       w_data,
  input  logic       busy,
  input  logic [7:0] data_out
);

  xfer_state_t state_q, state_d;
  logic [7:0]  tx_q;
  logic [7:0]  rx_q;
  logic        done_q;
  logic        capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= XferIdle;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= capture;
      if (go && state_q == XferIdle) tx_q <= tx;
      if (capture)                   rx_q <= data_out;
    end
  end

  always_comb begin
    state_d = state_q;
    w_data  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      XferIdle:   if (go) state_d = XferIssue;
      // Hold off while the master is still finishing an earlier (possibly aborted) byte.
      XferIssue: begin
        if (!busy) begin
          w_data  = 1'b1;
          state_d = XferWaitHi;
        end
      end
      XferWaitHi: if (busy) state_d = XferWaitLo;
      XferWaitLo: begin
        if (!busy) begin
          capture = 1'b1;
          state_d = XferIdle;
        end
      end
      default:    state_d = XferIdle;
    endcase
  end

  assign rx        = rx_q;
  assign byte_done = done_q;
  assign tx_byte   = tx_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Issues one complete SD SPI-mode command frame through a byte-level SPI master:
// load divider, select, 6 command bytes, poll for R1, read 0-4 response bytes,
// one 0xFF tail byte, deselect.
//  clk, rst   : clock, asynchronous active-low reset
//  start      : request, sampled only while ready
//  cmd_idx, cmd_arg, cmd_crc, resp_len, sclk_div : frame parameters, latched on start
//  ready      : idle
//  done       : 1-cycle end-of-frame pulse
//  timeout    : no R1 within NCR_MAX polls; held until the next start
//  r1         : R1 byte (0xFF on timeout)
//  resp_data  : trailing bytes, MSB first, right-aligned
//  spi        : link to the SPI master
module sd_cmd_sequencer
  import sd_spi_pkg::*;
#(
  parameter int unsigned NCR_MAX  = 8,
  parameter int unsigned RESP_MAX = RESP_MAX_C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [5:0]          cmd_idx,
  input  logic [31:0]         cmd_arg,
  input  logic [6:0]          cmd_crc,
  input  logic [2:0]          resp_len,
  input  logic [7:0]          sclk_div,
  output logic                ready,
  output logic                done,
  output logic                timeout,
  output logic [7:0]          r1,
  output logic [31:0]         resp_data,
  sd_cmd_sequencer_if.master  spi
);

  localparam int unsigned PollW = $clog2(NCR_MAX + 1);

  seq_state_t       state_q, state_d;
  logic             ss_q, ss_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       r1_q, r1_d;
  logic [31:0]      resp_q, resp_d;
  logic [2:0]       idx_q, idx_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic             inflight_q, inflight_d;

  logic [5:0]       cmd_idx_q;
  logic [31:0]      arg_q;
  logic [6:0]       crc_q;
  logic [2:0]       len_q;
  logic [7:0]       div_q;

  logic             accept;
  logic [2:0]       len_clamped;
  logic             byte_state;
  logic             go;
  logic [7:0]       tx;
  logic [7:0]       rx;
  logic             byte_done;
  logic [7:0]       tx_byte;

  assign accept      = (state_q == SeqIdle) && start;
  assign len_clamped = (resp_len > 3'(RESP_MAX)) ? 3'(RESP_MAX) : resp_len;
  assign byte_state  = (state_q == SeqCmd) || (state_q == SeqPoll) ||
                       (state_q == SeqResp) || (state_q == SeqTail);
  // One outstanding byte at a time; the next request goes out the cycle after byte_done.
  assign go          = byte_state && !inflight_q;
  assign tx          = (state_q == SeqCmd) ? cmd_byte(idx_q, cmd_idx_q, arg_q, crc_q) : FILL_BYTE;

  spi_byte_xfer u_xfer (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .tx        (tx),
    .rx        (rx),
    .byte_done (byte_done),
    .tx_byte   (tx_byte),
    .w_data    (spi.spi_w_data),
    .busy      (spi.spi_busy),
    .data_out  (spi.spi_data_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SeqIdle;
      ss_q       <= 1'b1;
      timeout_q  <= 1'b0;
      r1_q       <= 8'h00;
      resp_q     <= 32'h0;
      idx_q      <= 3'd0;
      poll_q     <= '0;
      inflight_q <= 1'b0;
      cmd_idx_q  <= 6'd0;
      arg_q      <= 32'h0;
      crc_q      <= 7'd0;
      len_q      <= 3'd0;
      div_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      ss_q       <= ss_d;
      timeout_q  <= timeout_d;
      r1_q       <= r1_d;
      resp_q     <= resp_d;
      idx_q      <= idx_d;
      poll_q     <= poll_d;
      inflight_q <= inflight_d;
      if (accept) begin
        cmd_idx_q <= cmd_idx;
        arg_q     <= cmd_arg;
        crc_q     <= cmd_crc;
        len_q     <= len_clamped;
        div_q     <= sclk_div;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ss_d       = ss_q;
    timeout_d  = timeout_q;
    r1_d       = r1_q;
    resp_d     = resp_q;
    idx_d      = idx_q;
    poll_d     = poll_q;
    inflight_d = inflight_q;
    if (go)        inflight_d = 1'b1;
    if (byte_done) inflight_d = 1'b0;

    unique case (state_q)
      SeqIdle: begin
        if (start) begin
          timeout_d = 1'b0;
          r1_d      = 8'h00;
          resp_d    = 32'h0;
          state_d   = SeqConf;
        end
      end
      SeqConf: begin
        ss_d    = 1'b0;
        state_d = SeqSel;
      end
      SeqSel: begin
        idx_d   = 3'd0;
        state_d = SeqCmd;
      end
      SeqCmd: begin
        if (byte_done) begin
          if (idx_q == 3'(CMD_BYTES - 1)) begin
            poll_d  = '0;
            state_d = SeqPoll;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      SeqPoll: begin
        if (byte_done) begin
          // A response byte is the first one with MSB clear; it wins even on the last poll.
          if (!rx[7]) begin
            r1_d    = rx;
            idx_d   = 3'd0;
            state_d = (len_q == 3'd0) ? SeqTail : SeqResp;
          end else if (poll_q == PollW'(NCR_MAX - 1)) begin
            timeout_d = 1'b1;
            r1_d      = FILL_BYTE;
            state_d   = SeqTail;
          end else begin
            poll_d = poll_q + PollW'(1);
          end
        end
      end
      SeqResp: begin
        if (byte_done) begin
          resp_d = {resp_q[23:0], rx};
          if (idx_q == len_q - 3'd1) state_d = SeqTail;
          else                       idx_d   = idx_q + 3'd1;
        end
      end
      SeqTail:  if (byte_done) state_d = SeqDesel;
      SeqDesel: begin
        ss_d    = 1'b1;
        state_d = SeqDone;
      end
      SeqDone:  state_d = SeqIdle;
      default:  state_d = SeqIdle;
    endcase
  end

  assign ready           = (state_q == SeqIdle);
  assign done            = (state_q == SeqDone);
  assign timeout         = timeout_q;
  assign r1              = r1_q;
  assign resp_data       = resp_q;
  assign spi.spi_w_conf  = (state_q == SeqConf);
  assign spi.spi_data_in = (state_q == SeqConf) ? div_q : tx_byte;
  assign spi.spi_ss_in   = ss_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench: behavioural SPI master with a scripted MISO card model.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic [2:0]  resp_len;
  logic [7:0]  sclk_div;
  logic        ready;
  logic        done;
  logic        timeout;
  logic [7:0]  r1;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  sd_cmd_sequencer_if sif ();

  sd_cmd_sequencer #(
    .NCR_MAX  (8),
    .RESP_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_idx   (cmd_idx),
    .cmd_arg   (cmd_arg),
    .cmd_crc   (cmd_crc),
    .resp_len  (resp_len),
    .sclk_div  (sclk_div),
    .ready     (ready),
    .done      (done),
    .timeout   (timeout),
    .r1        (r1),
    .resp_data (resp_data),
    .spi       (sif.master)
  );

  // SPI master + card model
  logic       m_busy = 1'b0;
  logic [7:0] m_dout = 8'hFF;
  logic [7:0] miso_q = 8'hFF;
  logic [7:0] conf_val = 8'h00;
  logic [7:0] mosi_log [0:255];
  logic [7:0] script [0:31];
  int         mosi_n = 0;
  int         fidx = 0;
  int         cnt = 0;
  int         done_cnt = 0;
  int         conf_cnt = 0;
  int         proto_err = 0;
  int         ss_bad = 0;

  assign sif.spi_busy     = m_busy;
  assign sif.spi_data_out = m_dout;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (sif.spi_w_conf) begin
      conf_cnt <= conf_cnt + 1;
      conf_val <= sif.spi_data_in;
      m_busy   <= 1'b0;
      fidx     <= 0;
    end else if (sif.spi_w_data) begin
      if (m_busy) begin
        proto_err <= proto_err + 1;
      end else begin
        if (sif.spi_ss_in) ss_bad <= ss_bad + 1;
        mosi_log[8'(mosi_n)] <= sif.spi_data_in;
        mosi_n <= mosi_n + 1;
        miso_q <= (fidx < 32) ? script[5'(fidx)] : 8'hFF;
        fidx   <= fidx + 1;
        m_busy <= 1'b1;
        cnt    <= 3;
      end
    end else if (m_busy) begin
      if (cnt == 1) begin
        m_busy <= 1'b0;
        m_dout <= miso_q;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  int         nvec = 0;
  int         nfail = 0;
  int         base = 0;
  int         d0 = 0;
  int         c0 = 0;
  logic [7:0] exp_b [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_script();
    for (int i = 0; i < 32; i++) script[i] = 8'hFF;
  endtask

  task automatic set_exp(input logic [7:0] b0, b1, b2, b3, b4, b5);
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    exp_b[3] = b3; exp_b[4] = b4; exp_b[5] = b5;
    for (int i = 6; i < 32; i++) exp_b[i] = 8'hFF;
  endtask

  task automatic launch(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                        input logic [2:0] len, input logic [7:0] div);
    cmd_idx  = idx;
    cmd_arg  = arg;
    cmd_crc  = crc;
    resp_len = len;
    sclk_div = div;
    @(negedge clk);
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    start = 1'b1;
    base  = mosi_n;
    d0    = done_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (mosi_n - base >= n) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("bytes_reached", {31'd0, seen}, 32'd1);
  endtask

  // Checks made in the DONE cycle: frame bytes and results.
  task automatic chk_results(input string tag, input int n, input logic [7:0] r1e,
                             input logic toe, input logic [31:0] respe, input logic [7:0] dive);
    chk({tag, "_nbytes"}, 32'(mosi_n - base), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_mosi%0d", tag, i), {24'd0, mosi_log[8'(base + i)]}, {24'd0, exp_b[i]});
    chk({tag, "_r1"}, {24'd0, r1}, {24'd0, r1e});
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, toe});
    chk({tag, "_resp"}, resp_data, respe);
    chk({tag, "_div"}, {24'd0, conf_val}, {24'd0, dive});
  endtask

  task automatic chk_after(input string tag);
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    chk({tag, "_ss_after"}, {31'd0, sif.spi_ss_in}, 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    cmd_idx  = 6'd0;
    cmd_arg  = 32'h0;
    cmd_crc  = 7'd0;
    resp_len = 3'd0;
    sclk_div = 8'h00;
    clear_script();
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ss", {31'd0, sif.spi_ss_in}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_r1", {24'd0, r1}, 32'd0);
    chk("rst_resp", resp_data, 32'd0);
    chk("rst_wdata", {31'd0, sif.spi_w_data}, 32'd0);
    chk("rst_wconf", {31'd0, sif.spi_w_conf}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0: R1=0x01 on the second poll byte
    clear_script();
    script[7] = 8'h01;
    set_exp(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95);
    launch(6'd0, 32'h0, 7'h4A, 3'd0, 8'h04);
    chk("cmd0_ss_low", {31'd0, sif.spi_ss_in}, 32'd1);
    @(negedge clk);
    chk("cmd0_ss_sel", {31'd0, sif.spi_ss_in}, 32'd0);
    wait_done("cmd0");
    chk_results("cmd0", 9, 8'h01, 1'b0, 32'h0, 8'h04);
    chk_after("cmd0");

    // CMD8: R1 then 4 trailing bytes
    clear_script();
    script[6] = 8'h01; script[7] = 8'h00; script[8] = 8'h00;
    script[9] = 8'h01; script[10] = 8'hAA;
    set_exp(8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87);
    launch(6'd8, 32'h0000_01AA, 7'h43, 3'd4, 8'h02);
    wait_done("cmd8");
    chk_results("cmd8", 12, 8'h01, 1'b0, 32'h0000_01AA, 8'h02);
    chk_after("cmd8");

    // Silent card: 8 polls, timeout, no response bytes, previous resp cleared
    clear_script();
    set_exp(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65);
    launch(6'd55, 32'h0, 7'h32, 3'd4, 8'h08);
    wait_done("silent");
    chk_results("silent", 15, 8'hFF, 1'b1, 32'h0, 8'h08);
    chk_after("silent");

    // R1 on the last allowed poll; resp_len=7 clamps to 4
    clear_script();
    script[13] = 8'h00; script[14] = 8'h11; script[15] = 8'h22;
    script[16] = 8'h33; script[17] = 8'h44;
    set_exp(8'h7A, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD);
    launch(6'd58, 32'h0, 7'h7E, 3'd7, 8'h10);
    wait_done("lastpoll");
    chk_results("lastpoll", 19, 8'h00, 1'b0, 32'h1122_3344, 8'h10);
    chk_after("lastpoll");

    // CMD17 with start pulsed mid-frame (different inputs) and in the DONE cycle
    clear_script();
    script[8] = 8'h05; script[9] = 8'hAB; script[10] = 8'hCD;
    set_exp(8'h51, 8'h00, 8'h00, 8'h02, 8'h00, 8'h55);
    launch(6'd17, 32'h0000_0200, 7'h2A, 3'd2, 8'h1F);
    wait_bytes(2);
    cmd_idx = 6'd0;
    cmd_arg = 32'hDEAD_BEEF;
    cmd_crc = 7'h00;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done("cmd17");
    chk_results("cmd17", 12, 8'h05, 1'b0, 32'h0000_ABCD, 8'h1F);
    c0    = conf_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cmd17_ready_post_done", {31'd0, ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("cmd17_one_done", 32'(done_cnt - d0), 32'd1);
    chk("cmd17_no_new_conf", 32'(conf_cnt - c0), 32'd0);
    chk("cmd17_no_new_bytes", 32'(mosi_n - base), 32'd12);
    chk("cmd17_ready_idle", {31'd0, ready}, 32'd1);

    // Reset during the third command byte, then a clean CMD0
    clear_script();
    script[7] = 8'h01;
    launch(6'd0, 32'h0, 7'h4A, 3'd0, 8'h04);
    wait_bytes(3);
    #1 rst = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_ss", {31'd0, sif.spi_ss_in}, 32'd1);
    chk("arst_wdata", {31'd0, sif.spi_w_data}, 32'd0);
    chk("arst_wconf", {31'd0, sif.spi_w_conf}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_exp(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95);
    launch(6'd0, 32'h0, 7'h4A, 3'd0, 8'h04);
    wait_done("recover");
    chk_results("recover", 9, 8'h01, 1'b0, 32'h0, 8'h04);
    chk_after("recover");

    chk("no_wdata_while_busy", 32'(proto_err), 32'd0);
    chk("no_bytes_deselected", 32'(ss_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
